// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, one bit per
// clock, LSB first. A start in IDLE captures the operands. SHIFT then runs
// for WIDTH cycles. DONE is a one-cycle state that presents the new sum and
// carry-out. The sum and carry outputs are registered. They change only on
// entry to DONE or on reset.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    // The counter must be able to hold WIDTH itself without wrapping.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] psum_reg;
    logic [WIDTH-1:0] psum_next;
    logic             c_reg;
    logic [CW-1:0]    cnt_reg;

    logic             bit_s;
    logic             bit_c;
    logic             last_bit;

    // Full-adder slice working on the current LSBs of the operand shifters.
    assign bit_s    = a_reg[0] ^ b_reg[0] ^ c_reg;
    assign bit_c    = (a_reg[0] & b_reg[0]) | (c_reg & (a_reg[0] ^ b_reg[0]));
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // The partial sum fills from the MSB side. After WIDTH shifts, the first
    // result bit has reached bit 0.
    always_comb begin
        psum_next            = psum_reg >> 1;
        psum_next[WIDTH-1]   = bit_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Start is only honoured in IDLE.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (start)    state_next = SHIFT;
            SHIFT:   if (last_bit) state_next = DONE;
            DONE:                  state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Moore outputs, decoded from the state alone.
    always_comb begin
        busy = (state_reg == SHIFT);
        done = (state_reg == DONE);
    end

    // Operand shifters, carry flip-flop, bit counter and partial sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            c_reg    <= 1'b0;
            cnt_reg  <= '0;
            psum_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            a_reg    <= a;
            b_reg    <= b;
            c_reg    <= cin;
            cnt_reg  <= '0;
            psum_reg <= '0;
        end else if (state_reg == SHIFT) begin
            a_reg    <= a_reg >> 1;
            b_reg    <= b_reg >> 1;
            c_reg    <= bit_c;
            cnt_reg  <= cnt_reg + CW'(1);
            psum_reg <= psum_next;
        end
    end

    // Result registers. On the final SHIFT edge they load the completed
    // sum, which includes the last bit being produced on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            carry <= 1'b0;
        end else if (state_reg == SHIFT && last_bit) begin
            sum   <= psum_next;
            carry <= bit_c;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8). A transaction-level model
// predicts busy/done/sum/carry from arithmetic and timing rules. A compare
// process checks every cycle. Directed scenarios also pin literal results.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         carry;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model. An accepted request occupies WIDTH busy cycles plus one done
    // cycle. The result (a+b+cin as WIDTH+1 bits) becomes visible with done.
    int         m_left;
    logic [W:0] m_pend;
    logic [W:0] m_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_pend <= '0;
            m_res  <= '0;
        end else if (m_left == 0) begin
            if (start) begin
                m_pend <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                m_left <= W + 1;
            end
        end else begin
            if (m_left == 2) m_res <= m_pend;
            m_left <= m_left - 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy",  {31'd0, busy},  {31'd0, (m_left > 1)});
            chk("done",  {31'd0, done},  {31'd0, (m_left == 1)});
            chk("sum",   {24'd0, sum},   {24'd0, m_res[W-1:0]});
            chk("carry", {31'd0, carry}, {31'd0, m_res[W]});
            if (done) done_cnt++;
        end
    end

    // Pulse start for one cycle. Optionally zero the operands once captured.
    // Then wait (bounded) for done and check the literal result.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic zero_after,
                          input logic [W-1:0] exp_sum, input logic exp_carry,
                          input string nm);
        int busy_n = 0;
        logic seen = 1'b0;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (zero_after) begin a = '0; b = '0; cin = 1'b0; end
        for (int i = 0; i < 20 && !seen; i++) begin
            if (busy) busy_n++;
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({nm, "_sum"},   {24'd0, sum},   {24'd0, exp_sum});
        chk({nm, "_carry"}, {31'd0, carry}, {31'd0, exp_carry});
        chk({nm, "_busy_cycles"}, busy_n, W);
        $display("op %s: a=%0d b=%0d cin=%0d -> sum=%0d carry=%0d", nm, ta, tb_, tc, sum, carry);
    endtask

    initial begin
        int d0;
        int last;
        int npulse;
        rst = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_sum",   {24'd0, sum},   32'd0);
        chk("rst_carry", {31'd0, carry}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(8'd3,   8'd5,   1'b0, 1'b0, 8'd8,   1'b0, "3p5");
        run_op(8'd255, 8'd1,   1'b0, 1'b0, 8'd0,   1'b1, "255p1");
        run_op(8'd255, 8'd255, 1'b1, 1'b0, 8'd255, 1'b1, "255p255c");

        // Second start while busy must be ignored.
        @(negedge clk);
        d0 = done_cnt;
        a = 8'd20; b = 8'd22; cin = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        a = 8'd1; b = 8'd1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (15) @(negedge clk);
        chk("ignore_sum", {24'd0, sum}, 32'd42);
        chk("ignore_done_pulses", done_cnt - d0, 32'd1);
        $display("op ignore: sum=%0d pulses=%0d", sum, done_cnt - d0);

        // Reset in the 4th SHIFT cycle aborts; no done afterwards.
        @(negedge clk);
        a = 8'd50; b = 8'd60; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",  {31'd0, busy},  32'd0);
        chk("abort_done",  {31'd0, done},  32'd0);
        chk("abort_sum",   {24'd0, sum},   32'd0);
        chk("abort_carry", {31'd0, carry}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        $display("op abort: sum=%0d pulses=%0d", sum, done_cnt - d0);
        run_op(8'd10, 8'd20, 1'b0, 1'b0, 8'd30, 1'b0, "10p20");

        // Start held high: done every WIDTH+2 cycles with the same result.
        @(negedge clk);
        a = 8'd100; b = 8'd27; cin = 1'b1; start = 1'b1;
        last = -1; npulse = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                chk("held_sum",   {24'd0, sum},   32'd128);
                chk("held_carry", {31'd0, carry}, 32'd0);
                if (last >= 0) chk("held_period", cyc - last, W + 2);
                $display("op held: cycle=%0d sum=%0d carry=%0d", cyc, sum, carry);
                last = cyc;
                npulse++;
            end
        end
        start = 1'b0;
        chk("held_pulses", npulse, 32'd4);
        repeat (12) @(negedge clk);

        // Operand changes during SHIFT do not affect the result.
        run_op(8'd7, 8'd9, 1'b0, 1'b1, 8'd16, 1'b0, "7p9_zeroed");

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a new addition; sampled on rising clk.
REQ-005 Port: a  input  WIDTH  operand A; captured with accepted start.
REQ-006 Port: b  input  WIDTH  operand B; captured with accepted start.
REQ-007 Port: cin  input  1  carry-in; captured with accepted start.
REQ-008 Port: busy  output  1  high while an addition is in progress (SHIFT state).
REQ-009 Port: done  output  1  one-cycle pulse; sum/carry hold the new result.
REQ-010 Port: sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 Port: carry  output  1  registered carry-out of the addition.

Function
REQ-012 The block SHALL add bit-serially, one bit per clock, LSB first, using full-adder equations: s=ai^bi^c, c'=(ai&bi)|(c&(ai^bi)).
REQ-013 The block SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-014 IDLE: start=1 at edge k SHALL capture a, b, cin into internal shift/carry registers, clear bit counter, enter SHIFT.
REQ-015 IDLE: start=0 SHALL remain in IDLE.
REQ-016 SHIFT: each edge SHALL process one bit, shift the result bit into an internal partial-sum register from the MSB side, update the carry flip-flop, increment the counter.
REQ-017 SHIFT SHALL last exactly WIDTH cycles; edge k+WIDTH SHALL enter DONE.
REQ-018 On entry to DONE the block SHALL load sum and carry outputs from the internal registers in the same edge.
REQ-019 DONE SHALL last one cycle, with done=1, then return to IDLE unconditionally.
REQ-020 Latency: done SHALL be high in the cycle following edge k+WIDTH, i.e. WIDTH+1 cycles after the accepting edge.
REQ-021 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE; both SHALL be Moore outputs.
REQ-022 start SHALL be ignored in SHIFT and DONE; a, b, cin changes during SHIFT SHALL NOT affect the result.
REQ-023 sum and carry SHALL hold the previous result during IDLE and SHIFT and change only on DONE entry or reset.
REQ-024 Start asserted in the IDLE cycle right after DONE SHALL be accepted (back-to-back throughput WIDTH+2 cycles).
REQ-025 The counter SHALL be sized to hold WIDTH without wrap; WIDTH=1 SHALL give one SHIFT cycle.
REQ-026 Overflow SHALL wrap sum modulo 2^WIDTH, with the overflow bit reported only on carry.

Reset
REQ-027 rst=1 SHALL, asynchronously and without a clock edge, force state IDLE, busy=0, done=0, sum=0, carry=0, and clear counter, shift and carry registers.
REQ-028 rst asserted mid-SHIFT SHALL abort the operation; no done pulse SHALL follow after release.
REQ-029 After rst deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-030 a=3, b=5, cin=0, start 1 cycle -> busy 8 cycles, then done pulse with sum=8, carry=0.
REQ-031 a=255, b=1, cin=0 -> sum=0, carry=1; a=255, b=255, cin=1 -> sum=255, carry=1.
REQ-032 Second start with a=1, b=1 pulsed while busy -> ignored; first result is unchanged, only one done pulse.
REQ-033 rst pulse at 4th SHIFT cycle -> outputs 0 immediately, no done; a subsequent start of a=10, b=20 -> sum=30.
REQ-034 start held high continuously with a=100, b=27, cin=1 -> done every 10 cycles, sum=128, carry=0 each time; sum held stable between pulses.
REQ-035 Operands changed during SHIFT (a=0, b=0) after capture of a=7, b=9 -> sum=16.
